mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter MAX_CONSEC, default 4, maximum consecutive MEM-side grants while an IF request waits; legal range 1..15.
REQ-004 Ports, in order:
  clk  in  1  rising-edge clock, sole clock;
  reset  in  1  synchronous, active-high;
  if_req  in  1  fetch request;
  if_addr  in  AW  fetch address;
  if_flush  in  1  pipeline flowChange, kills current fetch;
  if_ready  out  1  one-cycle pulse, fetch data valid;
  if_rdata  out  DW  fetch data;
  mem_req  in  1  data-access request;
  mem_we  in  1  1 means store, 0 means load;
  mem_addr  in  AW  data address;
  mem_wdata  in  DW  store data;
  mem_ready  out  1  one-cycle pulse, data access done;
  mem_rdata  out  DW  load data;
  stall_if  out  1  IF stage must hold;
  stall_mem  out  1  MEM stage must hold;
  m_req  out  1  memory request;
  m_we  out  1  memory write enable;
  m_addr  out  AW  memory address;
  m_wdata  out  DW  memory write data;
  m_ack  in  1  memory done, one-cycle pulse;
  m_rdata  in  DW  memory read data, valid with m_ack.

Function
REQ-005 The FSM SHALL have four states: IDLE, IF_BUSY, MEM_BUSY and IF_DROP.
REQ-006 In IDLE, mem_req SHALL win: the block latches mem_we, mem_addr and mem_wdata, then goes to MEM_BUSY.
REQ-007 Exception to REQ-006: if consec_cnt equals MAX_CONSEC and if_req=1 and if_flush=0, IF SHALL win instead.
REQ-008 In IDLE with only if_req=1 and if_flush=0, the block SHALL latch if_addr and go to IF_BUSY.
REQ-009 In IDLE, if_req together with if_flush=1 in the same cycle SHALL be ignored.
REQ-010 m_req, m_we, m_addr and m_wdata SHALL be registered.
  - m_req is high in every BUSY or DROP cycle.
  - m_we, m_addr and m_wdata stay stable from grant until m_ack.
  - Grant latency: request sampled at edge N gives m_req high after edge N.
REQ-011 m_ack in IF_BUSY SHALL register m_rdata into if_rdata, pulse if_ready for exactly the next cycle, and return to IDLE.
REQ-012 m_ack in MEM_BUSY SHALL register m_rdata into mem_rdata (loads only), pulse mem_ready for exactly the next cycle, and return to IDLE.
  - On a store, mem_rdata holds its previous value.
REQ-013 Minimum transaction time SHALL be 2 cycles: ack in the first m_req cycle gives ready one cycle later. No re-grant occurs in the ready cycle; the FSM is in IDLE.
REQ-014 if_flush in IF_BUSY SHALL move the FSM to IF_DROP, keeping m_req high.
  - m_ack in IF_DROP returns to IDLE with no if_ready and no change to if_rdata.
  - if_flush coinciding with m_ack in IF_BUSY suppresses if_ready.
REQ-015 if_flush SHALL have no effect in MEM_BUSY or IF_DROP.
REQ-016 m_ack received in IDLE SHALL be ignored.
REQ-017 consec_cnt (4 bits) SHALL be updated at each grant:
  - increments on a MEM grant while if_req=1;
  - clears on any IF grant;
  - clears on a MEM grant with if_req=0;
  - saturates at MAX_CONSEC.
REQ-018 stall_if SHALL equal if_req & ~if_flush & ~if_ready (combinational).
REQ-019 stall_mem SHALL equal mem_req & ~mem_ready (combinational).
REQ-020 A requester SHALL hold req and its address/data stable until its ready pulse; the block does not re-check them after the grant.

Reset
REQ-021 While reset=1 at a clock edge, the block SHALL force:
  - FSM to IDLE and consec_cnt to 0;
  - m_req, m_we, if_ready and mem_ready to 0;
  - m_addr, m_wdata, if_rdata and mem_rdata to 0.
REQ-022 Reset mid-transaction SHALL abandon the access; a late m_ack after reset falls under REQ-016.

Structure
REQ-023 FSM state encodings SHALL live in the shared package used by the pipeline control logic, as 2-bit localparams: IDLE=00, IF_BUSY=01, MEM_BUSY=10, IF_DROP=11.
REQ-024 The block SHALL be a single module with no sub-modules.
  - The starvation counter is inline.
  - Stall outputs are driven by continuous assigns.

Verification
REQ-025 The bench SHALL cover these scenarios:
  - Lone fetch: if_req=1, if_addr=0x100, memory acks in the first m_req cycle with 0x2402000A -> m_req high 1 cycle later; if_ready pulses at cycle 2 with if_rdata=0x2402000A; stall_if high cycles 0-1.
  - Simultaneous requests: if_req=mem_req=1, mem_we=1, mem_addr=0x200, mem_wdata=0x5 -> MEM granted first (m_we=1, m_addr=0x200); IF granted in the next IDLE.
  - Starvation: mem_req held high for 6 back-to-back accesses, if_req=1 throughout, MAX_CONSEC=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM,MEM.
  - Flush during fetch: if_flush pulsed in the 2nd IF_BUSY cycle, m_ack 3 cycles later -> no if_ready; if_rdata unchanged; a fresh if_req granted after returning to IDLE.
  - Reset in MEM_BUSY, then m_ack one cycle after reset deasserts -> all outputs 0; ack ignored; FSM stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// The 2-bit state codes are also consumed by pipeline control logic.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_IF_BUSY  = 2'b01;
  localparam logic [1:0] ST_MEM_BUSY = 2'b10;
  localparam logic [1:0] ST_IF_DROP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    IF_BUSY  = ST_IF_BUSY,
    MEM_BUSY = ST_MEM_BUSY,
    IF_DROP  = ST_IF_DROP
  } arb_state_e;

  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] max);
    return (v >= max) ? max : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data side wins by default; a saturating counter bounds how long a fetch can starve.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ready,
  output logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CONSEC);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] consec_q, consec_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [AW-1:0]    m_addr_q, m_addr_d;
  logic [DW-1:0]    m_wdata_q, m_wdata_d;
  logic             if_ready_q, if_ready_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic             mem_ready_q, mem_ready_d;
  logic [DW-1:0]    mem_rdata_q, mem_rdata_d;

  logic if_ok;
  logic ready_cyc;

  assign if_ok     = if_req & ~if_flush;
  // The requester still holds its request during its ready cycle; never re-grant then.
  assign ready_cyc = if_ready_q | mem_ready_q;

  always_comb begin
    state_d     = state_q;
    consec_d    = consec_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (!ready_cyc) begin
          if (mem_req && !(consec_q == MAX_C && if_ok)) begin
            state_d   = MEM_BUSY;
            m_req_d   = 1'b1;
            m_we_d    = mem_we;
            m_addr_d  = mem_addr;
            m_wdata_d = mem_wdata;
            consec_d  = if_req ? sat_inc(consec_q, MAX_C) : '0;
          end else if (if_ok) begin
            state_d  = IF_BUSY;
            m_req_d  = 1'b1;
            m_we_d   = 1'b0;
            m_addr_d = if_addr;
            consec_d = '0;
          end
        end
      end
      IF_BUSY: begin
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (!if_flush) begin
            if_ready_d = 1'b1;
            if_rdata_d = m_rdata;
          end
        end else if (if_flush) begin
          state_d = IF_DROP;
        end
      end
      MEM_BUSY: begin
        if (m_ack) begin
          state_d     = IDLE;
          m_req_d     = 1'b0;
          mem_ready_d = 1'b1;
          if (!m_we_q) mem_rdata_d = m_rdata;
        end
      end
      IF_DROP: begin
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      consec_q    <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      consec_q    <= consec_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;

  assign stall_if  = if_req & ~if_flush & ~if_ready_q;
  assign stall_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: requesters push expected responses, a monitor pops
// them on ready pulses, and a memory responder logs and checks every grant.
module tb_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0, reset = 1'b1;
  logic          if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0, mem_we = 1'b0, m_ack = 1'b0;
  logic [AW-1:0] if_addr = '0, mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0, m_rdata = '0;
  logic          if_ready, mem_ready, stall_if, stall_mem, m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] if_rdata, mem_rdata, m_wdata;

  mem_arb #(.AW(AW), .DW(DW), .MAX_CONSEC(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  logic [DW-1:0] exp_if_q[$], exp_mem_q[$];
  logic [DW-1:0] last_load = '0;   // data side's view of mem_rdata
  string glog = "";                // grant order, one letter per grant
  bit resp_en = 1'b1;
  int lat_max = 3;
  int lat_fixed = -1;

  // Memory contents as a pure function of address.
  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h2402000A;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    int n = 0;
    if_req = 1'b1; if_addr = a;
    exp_if_q.push_back(mdata(a));
    do begin @(negedge clk); n++; end while (!if_ready && n < 200);
    check("fetch_timeout", n < 200, 1);
    tick();
    if_req = 1'b0;
  endtask

  task automatic do_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n = 0;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd;
    if (!we) last_load = mdata(a);
    exp_mem_q.push_back(last_load);
    do begin @(negedge clk); n++; end while (!mem_ready && n < 200);
    check("mem_timeout", n < 200, 1);
    tick();
    mem_req = 1'b0;
  endtask

  // Memory responder: acks after a random or fixed latency, checks grant contents and hold.
  initial begin : responder
    bit in_tx = 1'b0;
    int cnt = 0;
    logic [AW-1:0] g_addr = '0;
    logic g_we = 1'b0;
    logic [DW-1:0] g_wd = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin in_tx = 1'b0; continue; end
      m_ack = 1'b0;
      if (reset || !m_req) begin in_tx = 1'b0; continue; end
      if (!in_tx) begin
        in_tx = 1'b1;
        cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, lat_max));
        g_addr = m_addr; g_we = m_we; g_wd = m_wdata;
        if (if_req && !m_we && m_addr == if_addr) glog = {glog, "I"};
        else begin
          glog = {glog, "M"};
          check("grant_addr", m_addr, mem_addr);
          check("grant_we", m_we, mem_we);
          if (m_we) check("grant_wdata", m_wdata, mem_wdata);
        end
      end else begin
        check("bus_hold", {m_we, m_addr, m_wdata}, {g_we, g_addr, g_wd});
      end
      if (cnt == 0) begin
        m_ack = 1'b1;
        m_rdata = g_we ? DW'($urandom) : mdata(g_addr);
      end else cnt--;
    end
  end

  // Monitor: pops scoreboard entries on each ready pulse.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("stall_if", stall_if, if_req & ~if_flush & ~if_ready);
        check("stall_mem", stall_mem, mem_req & ~mem_ready);
      end
      if (if_ready === 1'b1) begin
        check("if_ready_pending", exp_if_q.size() != 0, 1);
        if (exp_if_q.size() != 0) check("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (mem_ready === 1'b1) begin
        check("mem_ready_pending", exp_mem_q.size() != 0, 1);
        if (exp_mem_q.size() != 0) check("mem_rdata", mem_rdata, exp_mem_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] rd_before;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", m_req, 0);       check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);     check("rst_m_wdata", m_wdata, 0);
    check("rst_if_ready", if_ready, 0); check("rst_mem_ready", mem_ready, 0);
    check("rst_if_rdata", if_rdata, 0); check("rst_mem_rdata", mem_rdata, 0);
    tick();
    reset = 1'b0;

    // Random mixed traffic from both requesters.
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        do_fetch($urandom & 32'h0FFFFFFC);
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        do_mem(1'($urandom_range(0, 1)), ($urandom & 32'h0FFFFFFC) | 32'h10000000, $urandom);
      end
    join
    check("rand_if_drained", exp_if_q.size(), 0);
    check("rand_mem_drained", exp_mem_q.size(), 0);

    // Lone fetch with ack in the first m_req cycle.
    tick();
    lat_fixed = 0;
    if_req = 1'b1; if_addr = 32'h100;
    exp_if_q.push_back(32'h2402000A);
    @(negedge clk); check("lone_c0_mreq", m_req, 0);   check("lone_c0_stall", stall_if, 1);
    @(negedge clk); check("lone_c1_mreq", m_req, 1);   check("lone_c1_stall", stall_if, 1);
    check("lone_c1_addr", m_addr, 32'h100);
    @(negedge clk); check("lone_c2_ready", if_ready, 1); check("lone_c2_stall", stall_if, 0);
    check("lone_c2_mreq", m_req, 0);
    tick();
    if_req = 1'b0;
    @(negedge clk); check("lone_c3_pulse", if_ready, 0);
    lat_fixed = -1;

    // Simultaneous requests: data side first, then fetch.
    tick();
    glog = "";
    fork
      do_fetch(32'h300);
      do_mem(1'b1, 32'h200, 32'h5);
    join
    check_s("simul_order", glog, "MI");

    // Starvation bound: fetch waits through MAX_CONSEC data grants.
    tick();
    glog = "";
    fork
      do_fetch(32'h400);
      for (int k = 0; k < 6; k++) do_mem(1'(k), 32'h10000200 + 32'(k * 4), $urandom);
    join
    check_s("starve_order", glog, "MMMMIMM");

    // Flush handling.
    tick();
    lat_fixed = 4;
    rd_before = if_rdata;
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h500;
    tick();
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk); check("flush_idle_ignored", m_req, 0);
    tick();
    if_req = 1'b1; if_addr = 32'h600;
    tick();
    tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      check("flush_no_ready", if_ready, 0);
      if (c <= 5) check("flush_drop_mreq", m_req, 1);
      if (c == 6) check("flush_back_idle", m_req, 0);
    end
    check("flush_rdata_kept", if_rdata, rd_before);
    tick();
    lat_fixed = -1;
    do_fetch(32'h700);

    // Reset during a data access, then a late ack.
    tick();
    resp_en = 1'b0; m_ack = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10000800;
    tick();
    @(negedge clk); check("rst_mid_busy", m_req, 1);
    tick();
    reset = 1'b1; mem_req = 1'b0;
    tick();
    reset = 1'b0;
    last_load = '0;
    @(negedge clk);
    check("rst2_m_req", m_req, 0);       check("rst2_m_we", m_we, 0);
    check("rst2_m_addr", m_addr, 0);     check("rst2_m_wdata", m_wdata, 0);
    check("rst2_if_ready", if_ready, 0); check("rst2_mem_ready", mem_ready, 0);
    check("rst2_if_rdata", if_rdata, 0); check("rst2_mem_rdata", mem_rdata, 0);
    tick();
    m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    tick();
    m_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("late_ack_m_req", m_req, 0);
      check("late_ack_mem_ready", mem_ready, 0);
      check("late_ack_mem_rdata", mem_rdata, 0);
    end
    check("final_if_drained", exp_if_q.size(), 0);
    check("final_mem_drained", exp_mem_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
